branch_sequencer: RTL and testbench

Branch-resolution controller in the ID stage of the MIPS pipeline. It detects operand hazards for branch/jump instructions and stalls IF/ID until the operands are usable. It then evaluates the branch condition and issues a one-cycle registered PC redirect with IF/ID flush. For JAL it also produces the `$31` link write.

---
 rtl/branch_sequencer_pkg.sv | 25 ++
 rtl/branch_sequencer_cond_eval.sv | 24 ++
 rtl/branch_sequencer.sv | 147 ++++++++++++++
 tb/tb_branch_sequencer.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_sequencer_pkg.sv
// Shared encodings for the ID-stage branch sequencer: datapath width, link register,
// branch classes and FSM states.
package branch_sequencer_pkg;

  localparam int unsigned WORD_LEN = 32;
  localparam logic [4:0]  LINK_REG = 5'd31;

  typedef enum logic [2:0] {
    BrNone = 3'd0,
    BrJump = 3'd1,
    BrJal  = 3'd2,
    BrJr   = 3'd3,
    BrBeq  = 3'd4,
    BrBne  = 3'd5,
    BrBltz = 3'd6,
    BrBgez = 3'd7
  } br_type_e;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StHazWait  = 2'd1,
    StRedirect = 2'd2
  } state_e;

endpackage

// File: rtl/branch_sequencer_cond_eval.sv
// Combinational branch-condition evaluator: decides whether the ID branch is taken
// from its class and the two register operands.
module branch_cond_eval
  import branch_sequencer_pkg::*;
(
  input  logic [2:0]          id_br_type,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic [WORD_LEN-1:0] reg2,
  output logic                taken
);

  always_comb begin
    taken = 1'b0;
    case (br_type_e'(id_br_type))
      BrJump, BrJal, BrJr: taken = 1'b1;
      BrBeq:               taken = (reg1 == reg2);
      BrBne:               taken = (reg1 != reg2);
      BrBltz:              taken = reg1[WORD_LEN-1];
      BrBgez:              taken = ~reg1[WORD_LEN-1];
      default:             taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_sequencer.sv
// ID-stage branch resolution: operand hazard stall, registered one-cycle PC redirect
// with IF/ID flush, JAL link write. Optional BR_STATS_EN adds saturating counters.
module branch_sequencer
  import branch_sequencer_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [2:0]          id_br_type,
  input  logic [4:0]          id_src1,
  input  logic [4:0]          id_src2,
  input  logic [WORD_LEN-1:0] reg1,
  input  logic [WORD_LEN-1:0] reg2,
  input  logic [WORD_LEN-1:0] id_pc,
  input  logic [WORD_LEN-1:0] id_target,
  input  logic                ex_wb_en,
  input  logic [4:0]          ex_dest,
  input  logic                mem_mem_read,
  input  logic [4:0]          mem_dest,
  output logic                stall_if_id,
  output logic                flush_if_id,
  output logic                pc_sel,
  output logic [WORD_LEN-1:0] pc_target,
  output logic                link_we,
  output logic [4:0]          link_dest,
  output logic [WORD_LEN-1:0] link_data
`ifdef BR_STATS_EN
  ,
  output logic [WORD_LEN-1:0] stat_branches,
  output logic [WORD_LEN-1:0] stat_taken,
  output logic [WORD_LEN-1:0] stat_stall_cycles
`endif
);

  br_type_e br_type;
  state_e   state_q, state_d;
  logic     live, use_src1, use_src2, haz1, haz2, hazard;
  logic     taken, decide, redirect, is_jal;

  logic                redirect_q, link_we_q;
  logic [WORD_LEN-1:0] pc_target_q, link_data_q;
  logic [4:0]          link_dest_q;

  assign br_type = br_type_e'(id_br_type);
  assign live    = id_valid && (br_type != BrNone);
  assign is_jal  = (br_type == BrJal);

  always_comb begin
    use_src1 = 1'b0;
    use_src2 = 1'b0;
    case (br_type)
      BrJr, BrBltz, BrBgez: use_src1 = 1'b1;
      BrBeq, BrBne: begin
        use_src1 = 1'b1;
        use_src2 = 1'b1;
      end
      default: ;
    endcase
  end

  // $0 never carries a pending write, so index 0 is never hazardous.
  assign haz1 = (id_src1 != 5'd0) && ((ex_wb_en && ex_dest == id_src1) ||
                                      (mem_mem_read && mem_dest == id_src1));
  assign haz2 = (id_src2 != 5'd0) && ((ex_wb_en && ex_dest == id_src2) ||
                                      (mem_mem_read && mem_dest == id_src2));
  assign hazard = (use_src1 && haz1) || (use_src2 && haz2);

  assign stall_if_id = live && hazard && (state_q != StRedirect);

  branch_cond_eval u_cond_eval (
    .id_br_type (id_br_type),
    .reg1       (reg1),
    .reg2       (reg2),
    .taken      (taken)
  );

  always_comb begin
    state_d = state_q;
    decide  = 1'b0;
    case (state_q)
      StIdle: begin
        if (live) begin
          if (hazard) state_d = StHazWait;
          else        decide  = 1'b1;
        end
      end
      StHazWait: begin
        if (!live)        state_d = StIdle;
        else if (!hazard) decide  = 1'b1;
      end
      // ID holds a wrong-path instruction here; never evaluate it.
      StRedirect: state_d = StIdle;
      default:    state_d = StIdle;
    endcase
    if (decide) state_d = taken ? StRedirect : StIdle;
  end

  assign redirect = decide && taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      redirect_q  <= 1'b0;
      link_we_q   <= 1'b0;
      pc_target_q <= '0;
      link_data_q <= '0;
      link_dest_q <= 5'd0;
    end else begin
      state_q    <= state_d;
      redirect_q <= redirect;
      link_we_q  <= redirect && is_jal;
      if (redirect) pc_target_q <= (br_type == BrJr) ? reg1 : id_target;
      if (redirect && is_jal) begin
        link_data_q <= id_pc + WORD_LEN'(1);
        link_dest_q <= LINK_REG;
      end
    end
  end

  assign pc_sel      = redirect_q;
  assign flush_if_id = redirect_q;
  assign link_we     = link_we_q;
  assign pc_target   = pc_target_q;
  assign link_data   = link_data_q;
  assign link_dest   = link_dest_q;

`ifdef BR_STATS_EN
  logic [WORD_LEN-1:0] branches_q, taken_q, stalls_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      branches_q <= '0;
      taken_q    <= '0;
      stalls_q   <= '0;
    end else begin
      if (decide && branches_q != '1)      branches_q <= branches_q + WORD_LEN'(1);
      if (redirect && taken_q != '1)       taken_q    <= taken_q + WORD_LEN'(1);
      if (stall_if_id && stalls_q != '1)   stalls_q   <= stalls_q + WORD_LEN'(1);
    end
  end

  assign stat_branches     = branches_q;
  assign stat_taken        = taken_q;
  assign stat_stall_cycles = stalls_q;
`endif

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: stimulus pushes per-cycle expectations from a
// behavioural model, a negedge monitor pops and compares. Honours BR_STATS_EN.
module tb_branch_sequencer;
  import branch_sequencer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, id_valid, ex_wb_en, mem_mem_read;
  logic [2:0]  id_br_type;
  logic [4:0]  id_src1, id_src2, ex_dest, mem_dest;
  logic [31:0] reg1, reg2, id_pc, id_target;
  logic        stall_if_id, flush_if_id, pc_sel, link_we;
  logic [31:0] pc_target, link_data;
  logic [4:0]  link_dest;
`ifdef BR_STATS_EN
  logic [31:0] stat_branches, stat_taken, stat_stall_cycles;
`endif

  branch_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .id_valid     (id_valid),
    .id_br_type   (id_br_type),
    .id_src1      (id_src1),
    .id_src2      (id_src2),
    .reg1         (reg1),
    .reg2         (reg2),
    .id_pc        (id_pc),
    .id_target    (id_target),
    .ex_wb_en     (ex_wb_en),
    .ex_dest      (ex_dest),
    .mem_mem_read (mem_mem_read),
    .mem_dest     (mem_dest),
    .stall_if_id  (stall_if_id),
    .flush_if_id  (flush_if_id),
    .pc_sel       (pc_sel),
    .pc_target    (pc_target),
    .link_we      (link_we),
    .link_dest    (link_dest),
    .link_data    (link_data)
`ifdef BR_STATS_EN
    ,
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  typedef struct {
    logic        stall, redir, link_we;
    logic [31:0] target, ldata;
    logic [4:0]  ldest;
    logic [31:0] n_br, n_tk, n_st;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  bit   done = 1'b0;

  // Model state: what the outputs will show next cycle, plus event counts.
  bit          m_redir, m_link_we;
  logic [31:0] m_target, m_ldata, m_n_br, m_n_tk, m_n_st;
  logic [4:0]  m_ldest;

  function automatic bit src_hazard(logic [4:0] s);
    return (s != 0) && ((ex_wb_en && ex_dest == s) || (mem_mem_read && mem_dest == s));
  endfunction

  function automatic int n_sources(logic [2:0] t);
    if (t == 3 || t == 6 || t == 7) return 1;
    if (t == 4 || t == 5) return 2;
    return 0;
  endfunction

  function automatic bit cond_taken();
    case (id_br_type)
      3'd1, 3'd2, 3'd3: return 1'b1;
      3'd4: return reg1 == reg2;
      3'd5: return reg1 != reg2;
      3'd6: return $signed(reg1) < 0;
      3'd7: return $signed(reg1) >= 0;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] sat_inc(logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  task automatic model_reset();
    m_redir = 0; m_link_we = 0; m_target = 0; m_ldata = 0; m_ldest = 0;
    m_n_br = 0; m_n_tk = 0; m_n_st = 0;
  endtask

  // Push this cycle's expectation, advance the model across the edge, then clock.
  task automatic step();
    exp_t e;
    bit live, haz, dec, tk;
    int ns;
    ns   = n_sources(id_br_type);
    live = id_valid && (id_br_type != 3'd0);
    haz  = (ns >= 1 && src_hazard(id_src1)) || (ns == 2 && src_hazard(id_src2));
    e.stall = live && haz && !m_redir;
    e.redir = m_redir; e.link_we = m_link_we; e.target = m_target;
    e.ldata = m_ldata; e.ldest = m_ldest;
    e.n_br = m_n_br; e.n_tk = m_n_tk; e.n_st = m_n_st;
    q.push_back(e);
    if (rst) begin
      model_reset();
    end else begin
      dec = live && !haz && !m_redir;
      tk  = dec && cond_taken();
      if (e.stall) m_n_st = sat_inc(m_n_st);
      if (dec) m_n_br = sat_inc(m_n_br);
      if (tk) begin
        m_n_tk   = sat_inc(m_n_tk);
        m_target = (id_br_type == 3'd3) ? reg1 : id_target;
        if (id_br_type == 3'd2) begin
          m_ldata = id_pc + 32'd1;
          m_ldest = 5'd31;
        end
      end
      m_redir   = tk;
      m_link_we = tk && (id_br_type == 3'd2);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    rst = 0; id_valid = 0; id_br_type = 0; id_src1 = 0; id_src2 = 0;
    reg1 = 0; reg2 = 0; id_pc = 0; id_target = 0;
    ex_wb_en = 0; ex_dest = 0; mem_mem_read = 0; mem_dest = 0;
  endtask

  task automatic set_br(logic [2:0] t, logic [4:0] s1, logic [4:0] s2,
                        logic [31:0] r1, logic [31:0] r2, logic [31:0] pc,
                        logic [31:0] tgt);
    id_valid = 1; id_br_type = t; id_src1 = s1; id_src2 = s2;
    reg1 = r1; reg2 = r2; id_pc = pc; id_target = tgt;
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("stall_if_id", 32'(stall_if_id), 32'(e.stall));
        chk("pc_sel", 32'(pc_sel), 32'(e.redir));
        chk("flush_if_id", 32'(flush_if_id), 32'(e.redir));
        chk("link_we", 32'(link_we), 32'(e.link_we));
        chk("pc_target", pc_target, e.target);
        chk("link_data", link_data, e.ldata);
        chk("link_dest", 32'(link_dest), 32'(e.ldest));
`ifdef BR_STATS_EN
        chk("stat_branches", stat_branches, e.n_br);
        chk("stat_taken", stat_taken, e.n_tk);
        chk("stat_stall_cycles", stat_stall_cycles, e.n_st);
`endif
      end
    end
  end

  initial begin : stimulus
    set_idle();
    rst = 1;
    @(posedge clk); #1;
    model_reset();
    step();                 // reset cycle: outputs at reset values
    rst = 0;
    step();

    // BEQ taken, no hazard
    set_br(3'd4, 5'd1, 5'd2, 32'd5, 32'd5, 32'h20, 32'h40);
    step();
    set_idle(); step(); step();

    // BNE stalled two cycles by EX write to r3, then released
    set_br(3'd5, 5'd3, 5'd4, 32'd0, 32'd0, 32'h24, 32'h60);
    ex_wb_en = 1; ex_dest = 3;
    step(); step();
    ex_wb_en = 0; reg1 = 1; reg2 = 2;
    step();
    set_idle(); step(); step();

    // BEQ stalled by load in MEM on src2
    set_br(3'd4, 5'd6, 5'd7, 32'd9, 32'd9, 32'h28, 32'h70);
    mem_mem_read = 1; mem_dest = 7;
    step();
    mem_mem_read = 0;
    step();
    set_idle(); step();

    // JAL link write
    set_br(3'd2, 5'd0, 5'd0, 32'd0, 32'd0, 32'h10, 32'h80);
    step();
    set_idle(); step(); step();

    // JAL wraps link address
    set_br(3'd2, 5'd0, 5'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h84);
    step();
    set_idle(); step();

    // JR through $0 never stalls
    set_br(3'd3, 5'd0, 5'd0, 32'h1234_5678, 32'd0, 32'h30, 32'h90);
    ex_wb_en = 1; ex_dest = 0;
    step();
    set_idle(); step();

    // BLTZ / BGEZ on the sign boundary
    set_br(3'd6, 5'd2, 5'd0, 32'h8000_0000, 32'd0, 32'h34, 32'hA0);
    step();
    set_idle(); step();
    set_br(3'd7, 5'd2, 5'd0, 32'h8000_0000, 32'd0, 32'h38, 32'hB0);
    step();
    set_idle(); step();

    // Back-to-back: second branch sits in the REDIRECT slot
    set_br(3'd1, 5'd0, 5'd0, 32'd0, 32'd0, 32'h3C, 32'hC0);
    step();
    set_br(3'd4, 5'd1, 5'd1, 32'd3, 32'd3, 32'h40, 32'hD0);
    step();
    set_idle(); step();

    // Reset in the REDIRECT cycle
    set_br(3'd4, 5'd1, 5'd2, 32'd7, 32'd7, 32'h44, 32'hE0);
    step();
    rst = 1;
    step();
    set_idle(); step(); step();

    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom_range(0, 63) == 0);
      id_valid     = ($urandom_range(0, 3) != 0);
      id_br_type   = 3'($urandom_range(0, 7));
      id_src1      = 5'($urandom_range(0, 3));
      id_src2      = 5'($urandom_range(0, 3));
      reg2         = $urandom();
      reg1         = ($urandom_range(0, 2) == 0) ? reg2 : $urandom();
      id_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom();
      id_target    = $urandom();
      ex_wb_en     = $urandom_range(0, 1) == 1;
      ex_dest      = 5'($urandom_range(0, 3));
      mem_mem_read = $urandom_range(0, 2) == 0;
      mem_dest     = 5'($urandom_range(0, 3));
      step();
    end

    set_idle();
    @(negedge clk); @(negedge clk);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    done = 1'b1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
